playback_sequencer: RTL and testbench

PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

---
 rtl/playback_sequencer.sv | 159 +++++++++++++++
 tb/tb_playback_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/playback_sequencer.sv
// rtl/playback_sequencer.sv - record-then-replay entry buffer with timed display per entry
// Define PLAYBACK_LOOP_EN to let the loop input replay the buffer continuously.
module playback_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int TICK_W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       save,
  input  logic                       execute,
  input  logic                       stop,
  input  logic                       loop,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [TICK_W-1:0]          period,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, SAVING, WAITING, READ, DISPLAY} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [TICK_W-1:0]   timer_q, timer_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   save_data_q, save_data_d;
  logic                stop_pend_q, stop_pend_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                full_w, empty_w, loop_en;
  logic [TICK_W-1:0]   period_eff;

  assign full_w     = (count_q == CW'(DEPTH));
  assign empty_w    = (count_q == '0);
  assign period_eff = (period == '0) ? TICK_W'(1) : period;

`ifdef PLAYBACK_LOOP_EN
  assign loop_en = loop;
`else
  logic loop_unused;
  assign loop_unused = loop;
  assign loop_en     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    timer_d      = timer_q;
    overflow_d   = overflow_q;
    data_out_d   = data_out_q;
    save_data_d  = save_data_q;
    stop_pend_d  = stop_pend_q;
    case (state_q)
      IDLE: begin
        if (save) begin
          save_data_d = data_in;
          state_d     = SAVING;
        end
      end
      SAVING: begin
        count_d = count_q + CW'(1);
        state_d = WAITING;
      end
      WAITING: begin
        if (save && !full_w) begin
          save_data_d = data_in;
          state_d     = SAVING;
        end else begin
          if (save) overflow_d = 1'b1;
          if ((execute || full_w) && !empty_w) state_d = READ;
        end
      end
      READ: begin
        data_out_d  = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d    = rd_ptr_q + CW'(1);
        timer_d     = period_eff;
        stop_pend_d = stop;
        state_d     = DISPLAY;
      end
      DISPLAY: begin
        stop_pend_d = 1'b0;
        // A stop seen during READ is held so it still aborts on the first display cycle.
        if (stop || stop_pend_q) begin
          rd_ptr_d = '0;
          state_d  = WAITING;
        end else if (timer_q == TICK_W'(1)) begin
          if (rd_ptr_q != count_q) begin
            state_d = READ;
          end else if (loop_en) begin
            rd_ptr_d = '0;
            state_d  = READ;
          end else begin
            count_d    = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            state_d    = IDLE;
          end
        end else begin
          timer_d = timer_q - TICK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    data_valid_d = (state_d == DISPLAY);
    busy_d       = (state_d == READ) || (state_d == DISPLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      timer_q      <= '0;
      overflow_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      save_data_q  <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      timer_q      <= timer_d;
      overflow_q   <= overflow_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      save_data_q  <= save_data_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == SAVING) mem[count_q[AW-1:0]] <= save_data_q;
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign empty      = empty_w;
  assign full       = full_w;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb/tb_playback_sequencer.sv - scoreboard bench for playback_sequencer (DATA_W=8, DEPTH=4)
// Follows PLAYBACK_LOOP_EN to pick loop expectations.
module tb_playback_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        save = 1'b0;
  logic        execute = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  period = 8'd3;
  logic [7:0]  data_out;
  logic        data_valid, busy, empty, full, overflow;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  playback_sequencer #(.DATA_W(8), .DEPTH(4), .TICK_W(8)) dut (
    .clk(clk), .reset(reset), .save(save), .execute(execute), .stop(stop),
    .loop(loop), .data_in(data_in), .period(period), .data_out(data_out),
    .data_valid(data_valid), .busy(busy), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Each displayed cycle consumes one expected entry.
  always @(negedge clk) begin
    if (data_valid) begin
      if (sb.size() == 0) check("unexpected_valid", data_valid, 0);
      else check("data_out", data_out, sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_entry(input logic [7:0] val, input int per);
    int cycles = (per == 0) ? 1 : per;
    for (int i = 0; i < cycles; i++) sb.push_back(val);
  endtask

  task automatic save_entry(input logic [7:0] val);
    save = 1'b1;
    data_in = val;
    step();
    save = 1'b0;
    step();
  endtask

  task automatic start_exec();
    execute = 1'b1;
    step();
    execute = 1'b0;
  endtask

  task automatic run_until_idle(input int already, input int exp_cycles, input string tag);
    int n = already;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check(tag, n, exp_cycles);
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  initial begin
    step();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", data_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_ovf", overflow, 0);
    step();
    reset = 1'b0;

    // Two entries, period 3: 4-cycle cadence then one-shot clear.
    period = 8'd3;
    save_entry(8'h11);
    check("a_count1", count, 1);
    save_entry(8'h22);
    check("a_count2", count, 2);
    check("a_busy_wait", busy, 0);
    expect_entry(8'h11, 3);
    expect_entry(8'h22, 3);
    start_exec();
    check("a_read_busy", busy, 1);
    check("a_read_valid", data_valid, 0);
    run_until_idle(0, 8, "a_cycles");
    check("a_end_count", count, 0);
    check("a_end_empty", empty, 1);
    check("a_hold_dout", data_out, 8'h22);

    // Filling the buffer starts playback; save while busy is ignored.
    period = 8'd2;
    for (int i = 0; i < 4; i++) begin
      save_entry(8'h31 + 8'(i));
      expect_entry(8'h31 + 8'(i), 2);
    end
    check("b_full", full, 1);
    check("b_count4", count, 4);
    step();
    check("b_auto_busy", busy, 1);
    save = 1'b1;
    data_in = 8'h99;
    repeat (3) step();
    save = 1'b0;
    check("b_ovf", overflow, 0);
    check("b_count_busy", count, 4);
    run_until_idle(3, 12, "b_cycles");
    check("b_end_count", count, 0);

    // Save while full in WAITING drops the data and flags overflow.
    period = 8'd1;
    for (int i = 0; i < 4; i++) begin
      save_entry(8'h41 + 8'(i));
      expect_entry(8'h41 + 8'(i), 1);
    end
    save = 1'b1;
    data_in = 8'hEE;
    step();
    save = 1'b0;
    check("c_ovf", overflow, 1);
    check("c_count", count, 4);
    check("c_busy", busy, 1);
    run_until_idle(0, 8, "c_cycles");
    check("c_ovf_clr", overflow, 0);

    // Stop mid-display keeps contents; replay restarts from the first entry.
    period = 8'd3;
    save_entry(8'hA0);
    save_entry(8'hB0);
    expect_entry(8'hA0, 1);
    start_exec();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("d_stop_busy", busy, 0);
    check("d_stop_count", count, 2);
    check("d_stop_valid", data_valid, 0);
    check("d_stop_dout", data_out, 8'hA0);
    loop = 1'b1;
`ifdef PLAYBACK_LOOP_EN
    for (int r = 0; r < 2; r++) begin
      expect_entry(8'hA0, 3);
      expect_entry(8'hB0, 3);
    end
    start_exec();
    repeat (15) step();
    check("d_loop_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop = 1'b0;
    check("d_loop_stop_busy", busy, 0);
    check("d_loop_stop_count", count, 2);
    check("d_loop_drain", sb.size(), 0);
    expect_entry(8'hA0, 3);
    expect_entry(8'hB0, 3);
    start_exec();
    run_until_idle(0, 8, "d_final_cycles");
`else
    expect_entry(8'hA0, 3);
    expect_entry(8'hB0, 3);
    start_exec();
    run_until_idle(0, 8, "d_noloop_cycles");
    loop = 1'b0;
`endif
    check("d_end_count", count, 0);

    // Reset in the middle of a display.
    period = 8'd5;
    save_entry(8'h55);
    expect_entry(8'h55, 1);
    start_exec();
    step();
    reset = 1'b1;
    step();
    check("e_valid", data_valid, 0);
    check("e_dout", data_out, 0);
    check("e_count", count, 0);
    check("e_busy", busy, 0);
    check("e_empty", empty, 1);
    reset = 1'b0;
    check("e_drain", sb.size(), 0);

    // Period 0 behaves as 1: two-cycle cadence.
    period = 8'd0;
    save_entry(8'h61);
    save_entry(8'h62);
    expect_entry(8'h61, 0);
    expect_entry(8'h62, 0);
    start_exec();
    run_until_idle(0, 4, "f_cycles");
    check("f_count", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
